// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: writes NUM_WORDS 16-bit words from an externally supplied
// table to a 7-bit I2C slave as {addr+W, high byte, low byte} frames. Each byte
// is ACK-checked. A NACK aborts the frame, and the word is retried up to MAX_RETRY
// times before the sequence stops with an error.
module i2c_config_sequencer #(
    parameter int         NUM_WORDS = 10,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         CLK_DIV   = 4,
    parameter int         MAX_RETRY = 3,
    localparam int        IW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [15:0]   i_word,
    input  logic          i_sdat,
    output logic [IW-1:0] o_word_idx,
    output logic          o_sclk,
    output logic          o_sdat,
    output logic          o_oen,
    output logic          o_busy,
    output logic          o_finished,
    output logic          o_error
);
    localparam int            QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int            RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);
    localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);
    localparam logic [IW-1:0] ILAST = IW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t        state_q;
    logic [QW-1:0] qcnt_q;     // cycle within the current quarter
    logic [1:0]    ph_q;       // quarter within the current state
    logic [2:0]    bit_q;      // bit within the byte, MSB first
    logic [1:0]    byte_q;     // byte within the frame
    logic [23:0]   shreg_q;    // frame shifted out from bit 23
    logic [IW-1:0] idx_q;
    logic [RW-1:0] retry_q;
    logic          good_q;     // all three bytes of the last attempt were ACKed
    logic          sclk_q, sdat_q, oen_q, busy_q, fin_q, err_q;
    logic          qend;

    assign qend       = (qcnt_q == QLAST);
    assign o_word_idx = idx_q;
    assign o_sclk     = sclk_q;
    assign o_sdat     = sdat_q;
    assign o_oen      = oen_q;
    assign o_busy     = busy_q;
    assign o_finished = fin_q;
    assign o_error    = err_q;

    // Sequencer FSM. Bus levels are registered. On each quarter boundary they are
    // loaded with the values for the quarter that is about to begin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            good_q  <= 1'b0;
            sclk_q  <= 1'b1;
            sdat_q  <= 1'b1;
            oen_q   <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) begin
            if (i_start) begin
                state_q <= S_START;
                qcnt_q  <= '0;
                ph_q    <= '0;
                idx_q   <= '0;
                retry_q <= '0;
                fin_q   <= 1'b0;
                err_q   <= 1'b0;
                busy_q  <= 1'b1;
            end
        end else if (!qend) begin
            qcnt_q <= qcnt_q + 1'b1;
        end else begin
            qcnt_q <= '0;
            ph_q   <= ph_q + 2'd1;
            case (state_q)
                S_START: begin
                    if (ph_q == 2'd0) begin
                        sdat_q <= 1'b0;
                    end else begin
                        // The word index is stable by now, so the table lookup is valid.
                        state_q <= S_BIT;
                        ph_q    <= '0;
                        sclk_q  <= 1'b0;
                        bit_q   <= '0;
                        byte_q  <= '0;
                        shreg_q <= {DEV_ADDR, 1'b0, i_word};
                    end
                end
                S_BIT: begin
                    if (ph_q == 2'd0) begin
                        sdat_q <= shreg_q[23];
                    end else if (ph_q == 2'd1) begin
                        sclk_q <= 1'b1;
                    end else if (ph_q == 2'd3) begin
                        sclk_q  <= 1'b0;
                        shreg_q <= {shreg_q[22:0], 1'b0};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_ACK;
                            oen_q   <= 1'b0;
                        end
                    end
                end
                S_ACK: begin
                    if (ph_q == 2'd1) begin
                        sclk_q <= 1'b1;
                    end else if (ph_q == 2'd3) begin
                        oen_q  <= 1'b1;
                        sclk_q <= 1'b0;
                        if (!i_sdat && byte_q != 2'd2) begin
                            state_q <= S_BIT;
                            byte_q  <= byte_q + 2'd1;
                        end else begin
                            // The last byte was ACKed, or any byte was NACKed: close the frame.
                            state_q <= S_STOP;
                            sdat_q  <= 1'b0;
                            good_q  <= !i_sdat;
                        end
                    end
                end
                S_STOP: begin
                    if (ph_q == 2'd0) begin
                        sclk_q <= 1'b1;
                    end else if (ph_q == 2'd1) begin
                        sdat_q <= 1'b1;
                    end else begin
                        state_q <= S_GAP;
                        ph_q    <= '0;
                    end
                end
                S_GAP: begin
                    if (ph_q == 2'd3) begin
                        if (good_q) begin
                            if (idx_q == ILAST) begin
                                state_q <= S_DONE;
                                fin_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                retry_q <= '0;
                                state_q <= S_START;
                            end
                        end else if (retry_q != RMAX) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= S_START;
                        end else begin
                            // o_word_idx is left pointing at the word that failed.
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer. u_dut (CLK_DIV=2) runs table-driven vectors,
// hand-written restart and reset cases, and randomized NACK patterns.
// u_dut1 (CLK_DIV=1) covers the single-cycle quarter boundary. A bus-level
// slave decodes bytes and answers ACK slots from a response list. That list
// is produced by a transaction-level model of the retry rules.
module tb_i2c_config_sequencer;
    localparam int NW = 2;
    localparam int MR = 3;
    localparam int D0 = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] start, sclk, sdo, oen, busy, fin, err, sdi;
    logic [0:0] idx0, idx1;
    logic [15:0] words [NW];

    int n_chk  = 0;
    int n_fail = 0;

    // model outputs
    bit         resp [$];
    logic [7:0] exp_bytes [$];
    int         e_starts, e_slots, e_q, e_idx;
    bit         e_fin, e_err;

    typedef struct {
        logic [15:0] w0, w1;
        int nw, nb, nt;   // NACK word/byte, and on how many attempts
        int cyc;
        bit fin, err;
        int idx;
    } vec_t;
    vec_t tbl [6];

    i2c_config_sequencer #(.NUM_WORDS(NW), .DEV_ADDR(7'h1A), .CLK_DIV(D0), .MAX_RETRY(MR)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_word(words[idx0]),
        .i_sdat(sdi[0]), .o_word_idx(idx0), .o_sclk(sclk[0]), .o_sdat(sdo[0]),
        .o_oen(oen[0]), .o_busy(busy[0]), .o_finished(fin[0]), .o_error(err[0])
    );

    i2c_config_sequencer #(.NUM_WORDS(NW), .DEV_ADDR(7'h1A), .CLK_DIV(1), .MAX_RETRY(MR)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_word(words[idx1]),
        .i_sdat(sdi[1]), .o_word_idx(idx1), .o_sclk(sclk[1]), .o_sdat(sdo[1]),
        .o_oen(oen[1]), .o_busy(busy[1]), .o_finished(fin[1]), .o_error(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus slave and decoder for each DUT. Only bus 0 takes its ACK/NACK answers from the response list.
    for (genvar g = 0; g < 2; g++) begin : g_bus
        logic       ps, pd, cand, cbit, low;
        logic [7:0] sh;
        int         bc, n_start, n_glitch, n_oen0, rp;
        logic [7:0] got [$];

        assign sdi[g] = (oen[g] ? sdo[g] : 1'b1) & ~low;

        always @(negedge clk) begin
            if (!rst_n) begin
                ps <= 1'b1; pd <= 1'b1; cand <= 1'b0; cbit <= 1'b0; low <= 1'b0; sh <= '0;
                bc <= 0; n_start <= 0; n_glitch <= 0; n_oen0 <= 0; rp <= 0;
                got.delete();
            end else begin
                ps <= sclk[g];
                pd <= sdi[g];
                if (!oen[g]) n_oen0 <= n_oen0 + 1;
                if (ps && sclk[g] && (pd != sdi[g])) begin
                    if (bc != 0) n_glitch <= n_glitch + 1;
                    if (!sdi[g]) n_start <= n_start + 1;
                    bc   <= 0;
                    cand <= 1'b0;
                end else if (!ps && sclk[g]) begin
                    cand <= oen[g];
                    cbit <= sdi[g];
                end else if (ps && !sclk[g]) begin
                    cand <= 1'b0;
                    low  <= 1'b0;
                    if (cand) begin
                        sh <= {sh[6:0], cbit};
                        if (bc == 7) begin
                            bc <= 0;
                            got.push_back({sh[6:0], cbit});
                            low <= (g == 0 && rp < resp.size()) ? ~resp[rp] : 1'b1;
                            if (g == 0) rp <= rp + 1;
                        end else begin
                            bc <= bc + 1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model. Walks words and attempts per the retry rules. It
    // appends one slave answer per transmitted byte and totals the quarters.
    task automatic build_expect(input bit rnd, input int nw, input int nb, input int nt);
        int w, r;
        bit good, nk, done;
        logic [23:0] fr;
        exp_bytes.delete();
        e_starts = 0; e_slots = 0; e_q = 0; e_fin = 0; e_err = 0; e_idx = 0;
        w = 0; r = 0; done = 0;
        while (!done) begin
            e_starts++;
            e_q += 2 + 3 + 4;
            fr = {7'h1A, 1'b0, words[w]};
            good = 1;
            for (int b = 0; b < 3; b++) begin
                exp_bytes.push_back(fr[23-8*b -: 8]);
                e_q += 36;
                e_slots++;
                nk = rnd ? ($urandom_range(0, 5) == 0) : (w == nw && b == nb && r < nt);
                resp.push_back(nk);
                if (nk) begin
                    good = 0;
                    break;
                end
            end
            if (good) begin
                if (w == NW - 1) begin e_fin = 1; e_idx = w; done = 1; end
                else begin w++; r = 0; end
            end else if (r < MR) begin
                r++;
            end else begin
                e_err = 1; e_idx = w; done = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = '0;
        resp.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One complete sequence on u_dut. ecyc is measured from the edge that samples i_start
    // to the edge that raises o_finished or o_error. poke>0 pulses i_start while busy.
    task automatic run0(input string nm, input int ecyc, input bit efin, input bit eerr,
                        input int eidx, input int poke);
        int s0, b0, o0, t, lim;
        s0 = g_bus[0].n_start;
        b0 = g_bus[0].got.size();
        o0 = g_bus[0].n_oen0;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " busy_on"}, busy[0], 1);
        chk({nm, " flags_clr"}, {fin[0], err[0]}, 0);
        chk({nm, " idx0"}, idx0, 0);
        @(negedge clk);
        start[0] = 1'b0;
        t = 0;
        lim = ecyc + 400;
        while (!(fin[0] | err[0]) && t < lim) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            start[0] = (t == poke);
        end
        start[0] = 1'b0;
        chk({nm, " cycles"}, t, ecyc);
        chk({nm, " finished"}, fin[0], efin);
        chk({nm, " error"}, err[0], eerr);
        chk({nm, " busy_off"}, busy[0], 0);
        chk({nm, " idx"}, idx0, eidx);
        chk({nm, " starts"}, g_bus[0].n_start - s0, e_starts);
        chk({nm, " oen0_cycles"}, g_bus[0].n_oen0 - o0, e_slots * 4 * D0);
        chk({nm, " glitch"}, g_bus[0].n_glitch, 0);
        chk({nm, " bus_idle"}, {sclk[0], sdo[0], oen[0]}, 3'b111);
        chk({nm, " nbytes"}, g_bus[0].got.size() - b0, exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            if (b0 + i < g_bus[0].got.size())
                chk({nm, " byte"}, g_bus[0].got[b0+i], exp_bytes[i]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end (n_chk=%0d)", n_chk);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h1E00, 16'h0C00, 0, 0, 0,  468, 1'b1, 1'b0, 1};  // all ACK
        tbl[1] = '{16'h1E00, 16'h0C00, 0, 2, 1,  702, 1'b1, 1'b0, 1};  // data byte NACK once
        tbl[2] = '{16'h1234, 16'h5678, 0, 0, 99, 360, 1'b0, 1'b1, 0};  // address NACK forever
        tbl[3] = '{16'hABCD, 16'h00FF, 1, 1, 2,  792, 1'b1, 1'b0, 1};  // word 1 hi byte NACK twice
        tbl[4] = '{16'h0F0F, 16'hF0F0, 1, 1, 99, 882, 1'b0, 1'b1, 1};  // word 1 exhausts retries
        tbl[5] = '{16'h8001, 16'h7FFE, 0, 0, 3,  738, 1'b1, 1'b0, 1};  // last allowed retry succeeds

        rst_n = 1'b0;
        start = '0;
        words[0] = '0;
        words[1] = '0;
        repeat (2) @(negedge clk);
        chk("reset sclk", sclk[0], 1);
        chk("reset sdat", sdo[0], 1);
        chk("reset oen", oen[0], 1);
        chk("reset busy/fin/err", {busy[0], fin[0], err[0]}, 0);
        chk("reset idx", idx0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            words[0] = tbl[v].w0;
            words[1] = tbl[v].w1;
            build_expect(1'b0, tbl[v].nw, tbl[v].nb, tbl[v].nt);
            run0($sformatf("vec%0d", v), tbl[v].cyc, tbl[v].fin, tbl[v].err, tbl[v].idx, 0);
            if (v == 0) begin
                // restart from DONE without reset, with a stray i_start mid-sequence
                build_expect(1'b0, 0, 0, 0);
                run0("restart", 468, 1'b1, 1'b0, 1, 300);
            end
        end

        // asynchronous reset during bit 5 of byte 1
        do_reset();
        words[0] = 16'h1E00;
        words[1] = 16'h0C00;
        build_expect(1'b0, 0, 0, 0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 2000 && !(g_bus[0].got.size() == 1 && g_bus[0].bc == 5); k++)
            @(negedge clk);
        chk("midreset reached bit5", (g_bus[0].got.size() == 1 && g_bus[0].bc == 5), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset bus", {sclk[0], sdo[0], oen[0]}, 3'b111);
        chk("midreset flags", {busy[0], fin[0], err[0]}, 0);
        chk("midreset idx", idx0, 0);
        resp.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        build_expect(1'b0, 0, 0, 0);
        run0("post_reset", 468, 1'b1, 1'b0, 1, 0);

        // CLK_DIV=1 instance, slave always ACKs
        begin
            int t;
            logic [7:0] e1 [6];
            do_reset();
            words[0] = 16'hA5C3;
            words[1] = 16'h5A3C;
            e1[0] = 8'h34; e1[1] = 8'hA5; e1[2] = 8'hC3;
            e1[3] = 8'h34; e1[4] = 8'h5A; e1[5] = 8'h3C;
            @(negedge clk);
            start[1] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start[1] = 1'b0;
            t = 0;
            while (!(fin[1] | err[1]) && t < 600) begin
                @(posedge clk);
                t++;
                @(negedge clk);
            end
            chk("div1 cycles", t, 234);
            chk("div1 finished", fin[1], 1);
            chk("div1 error", err[1], 0);
            chk("div1 starts", g_bus[1].n_start, 2);
            chk("div1 oen0_cycles", g_bus[1].n_oen0, 24);
            chk("div1 glitch", g_bus[1].n_glitch, 0);
            chk("div1 nbytes", g_bus[1].got.size(), 6);
            for (int i = 0; i < 6; i++)
                if (i < g_bus[1].got.size())
                    chk("div1 byte", g_bus[1].got[i], e1[i]);
        end

        // randomized words and NACK patterns against the model
        for (int n = 0; n < 10; n++) begin
            do_reset();
            words[0] = 16'($urandom);
            words[1] = 16'($urandom);
            build_expect(1'b1, 0, 0, 0);
            run0($sformatf("rnd%0d", n), e_q * D0, e_fin, e_err, e_idx,
                 int'($urandom_range(0, 200)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
